custom_mem_port_mux: RTL and testbench

- Parametrised N-to-1 MEM-port multiplexer for the custom core wrapper area.
- Merges NUM_CH MEM master ports into one MEM master port. Typical inputs are a core's instr/data ports, or several harts' ports.
- Arbitration is round-robin with locked selection.
- An in-order channel-ID FIFO tracks up to MAX_OUTSTANDING requests and routes each response to the channel that issued it.

---
 rtl/custom_mem_port_mux.sv | 151 +++++++++++++++
 tb/tb_custom_mem_port_mux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_mem_port_mux.sv
// N-to-1 MEM-port multiplexer: round-robin arbitration with locked selection and an
// in-order channel-ID FIFO for response routing. Define MEM_PORT_MUX_RESP_REG_EN to register responses.
module custom_mem_port_mux #(
  parameter int NUM_CH          = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              s_mem_req,
  output logic [NUM_CH-1:0]              s_mem_gnt,
  output logic [NUM_CH-1:0]              s_mem_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_mem_wdata,
  input  logic [NUM_CH-1:0]              s_mem_we,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_mem_be,
  output logic [NUM_CH*DATA_WIDTH-1:0]   s_mem_rdata,
  output logic                           m_mem_req,
  input  logic                           m_mem_gnt,
  input  logic                           m_mem_valid,
  output logic [ADDR_WIDTH-1:0]          m_mem_addr,
  output logic [DATA_WIDTH-1:0]          m_mem_wdata,
  output logic                           m_mem_we,
  output logic [DATA_WIDTH/8-1:0]        m_mem_be,
  input  logic [DATA_WIDTH-1:0]          m_mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                           orphan_err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int ID_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 2) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  rr_ptr;
  logic             lock_vld;
  logic [ID_W-1:0]  lock_ch;
  logic [ID_W-1:0]  scan_sel;
  logic             scan_hit;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  sel_inc;
  logic [ID_W-1:0]  id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  head;
  logic             orphan_err;
  logic             full;
  logic             push;
  logic             pop;
  logic [NUM_CH-1:0]            resp_vld;
  logic [NUM_CH*DATA_WIDTH-1:0] resp_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester at or after rr_ptr, scanning upward with wrap
  always_comb begin
    int idx;
    idx      = 0;
    scan_sel = rr_ptr;
    scan_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!scan_hit && s_mem_req[idx]) begin
        scan_sel = ID_W'(idx);
        scan_hit = 1'b1;
      end
    end
  end

  // A locked channel that dropped its request falls back to the scan this cycle
  assign sel     = (lock_vld && s_mem_req[lock_ch]) ? lock_ch : scan_sel;
  assign sel_inc = (sel == ID_W'(NUM_CH - 1)) ? '0 : sel + ID_W'(1);

  assign head = id_mem[rd_ptr];
  assign pop  = m_mem_valid && (count != '0);
  assign full = (count == CNT_W'(MAX_OUTSTANDING)) && !pop;

  assign m_mem_req   = (|s_mem_req) && !full;
  assign push        = m_mem_req && m_mem_gnt;
  assign m_mem_addr  = s_mem_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_mem_wdata = s_mem_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign m_mem_we    = s_mem_we[sel];
  assign m_mem_be    = s_mem_be[int'(sel)*BE_W +: BE_W];

  always_comb begin
    s_mem_gnt      = '0;
    s_mem_gnt[sel] = push;
  end

  always_comb begin
    resp_vld = '0;
    if (pop) resp_vld[head] = 1'b1;
  end

  assign resp_data     = {NUM_CH{m_mem_rdata}};
  assign outstanding_o = count;
  assign orphan_err_o  = orphan_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_ch    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (push) rr_ptr <= sel_inc;
      lock_vld <= m_mem_req && !m_mem_gnt;
      if (m_mem_req && !m_mem_gnt) lock_ch <= sel;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (m_mem_valid && (count == '0)) orphan_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

`ifdef MEM_PORT_MUX_RESP_REG_EN
  logic [NUM_CH-1:0]            resp_vld_p0;
  logic [NUM_CH*DATA_WIDTH-1:0] resp_data_p0;

  // Response register stage: one extra cycle of response latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld_p0  <= '0;
      resp_data_p0 <= '0;
    end else begin
      resp_vld_p0  <= resp_vld;
      resp_data_p0 <= resp_data;
    end
  end

  assign s_mem_valid = resp_vld_p0;
  assign s_mem_rdata = resp_data_p0;
`else
  assign s_mem_valid = resp_vld;
  assign s_mem_rdata = resp_data;
`endif

endmodule

// File: tb/tb_custom_mem_port_mux.sv
// Directed bench for custom_mem_port_mux: stimulus pushes expected responses into a
// scoreboard, a negedge monitor pops and checks every s_mem_valid pulse.
module tb_custom_mem_port_mux;
  localparam int NUM_CH = 2;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int MO     = 4;
  localparam int CW     = $clog2(MO + 1);
`ifdef MEM_PORT_MUX_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        s_mem_req;
  logic [NUM_CH-1:0]        s_mem_gnt;
  logic [NUM_CH-1:0]        s_mem_valid;
  logic [NUM_CH*AW-1:0]     s_mem_addr;
  logic [NUM_CH*DW-1:0]     s_mem_wdata;
  logic [NUM_CH-1:0]        s_mem_we;
  logic [NUM_CH*DW/8-1:0]   s_mem_be;
  logic [NUM_CH*DW-1:0]     s_mem_rdata;
  logic                     m_mem_req;
  logic                     m_mem_gnt;
  logic                     m_mem_valid;
  logic [AW-1:0]            m_mem_addr;
  logic [DW-1:0]            m_mem_wdata;
  logic                     m_mem_we;
  logic [DW/8-1:0]          m_mem_be;
  logic [DW-1:0]            m_mem_rdata;
  logic [CW-1:0]            outstanding;
  logic                     orphan_err;

  custom_mem_port_mux #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_valid(s_mem_valid),
    .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata), .s_mem_we(s_mem_we),
    .s_mem_be(s_mem_be), .s_mem_rdata(s_mem_rdata),
    .m_mem_req(m_mem_req), .m_mem_gnt(m_mem_gnt), .m_mem_valid(m_mem_valid),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata), .m_mem_we(m_mem_we),
    .m_mem_be(m_mem_be), .m_mem_rdata(m_mem_rdata),
    .outstanding_o(outstanding), .orphan_err_o(orphan_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_mem_valid[c] === 1'b1) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_valid_ch%0d", c), s_mem_valid[c], 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_channel", c, e.ch);
          chk("resp_rdata", s_mem_rdata[c*DW +: DW], e.data);
          chk("resp_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input int ch, input logic [31:0] data);
    m_mem_valid = 1'b1;
    m_mem_rdata = data;
    sb.push_back('{ch, data, cyc + LAT});
  endtask

  initial begin
    rst         = 1'b1;
    s_mem_req   = '0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_we    = '0;
    s_mem_be    = '0;
    m_mem_gnt   = 1'b0;
    m_mem_valid = 1'b0;
    m_mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_orphan", orphan_err, 0);
    chk("reset_gnt", s_mem_gnt, 0);
    chk("reset_valid", s_mem_valid, 0);
    chk("reset_m_req", m_mem_req, 0);
    chk("reset_rdata", s_mem_rdata, 0);
    tick();

    // Round-robin alternation with both channels requesting every cycle
    s_mem_addr  = {32'h0000_0200, 32'h0000_0100};
    s_mem_wdata = {32'h0000_DEAD, 32'h0000_BEEF};
    s_mem_we    = 2'b10;
    s_mem_be    = {4'hF, 4'h3};
    s_mem_req   = 2'b11;
    m_mem_gnt   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt_%0d", k), s_mem_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_addr_%0d", k), m_mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      if (k == 1) begin
        chk("fwd_wdata_ch1", m_mem_wdata, 32'hDEAD);
        chk("fwd_we_be_ch1", {m_mem_we, m_mem_be}, {1'b1, 4'hF});
      end
      tick();
    end
    s_mem_req = '0;
    m_mem_gnt = 1'b0;
    @(negedge clk);
    chk("rr_outstanding_4", outstanding, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      resp(k % 2, 32'hA0 + k);
      tick();
    end
    m_mem_valid = 1'b0;
    @(negedge clk);
    chk("rr_drained", outstanding, 0);
    tick();
    tick();

    // FIFO full blocks requests; a pop frees the slot in the same cycle
    s_mem_req = 2'b01;
    m_mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fill_gnt_%0d", k), s_mem_gnt, 2'b01);
      tick();
    end
    @(negedge clk);
    chk("full_m_req", m_mem_req, 0);
    chk("full_outstanding", outstanding, 4);
    chk("full_gnt", s_mem_gnt, 0);
    tick();
    resp(0, 32'hB0);
    @(negedge clk);
    chk("full_pop_m_req", m_mem_req, 1);
    chk("full_pop_gnt", s_mem_gnt, 2'b01);
    tick();
    m_mem_valid = 1'b0;
    s_mem_req   = '0;
    m_mem_gnt   = 1'b0;
    @(negedge clk);
    chk("full_pop_outstanding", outstanding, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      resp(0, 32'hB1 + k);
      tick();
    end
    m_mem_valid = 1'b0;
    tick();

    // One ch1 transaction to bring rr_ptr back to 0
    s_mem_req = 2'b10;
    m_mem_gnt = 1'b1;
    tick();
    s_mem_req = '0;
    m_mem_gnt = 1'b0;
    resp(1, 32'hC9);
    tick();
    m_mem_valid = 1'b0;
    tick();

    // Lock holds ch1 while the downstream stalls, even after ch0 starts requesting
    s_mem_addr = {32'h0000_1000, 32'h0000_0100};
    s_mem_req  = 2'b10;
    @(negedge clk);
    chk("lock_first_addr", m_mem_addr, 32'h1000);
    chk("lock_first_m_req", m_mem_req, 1);
    chk("lock_first_gnt", s_mem_gnt, 0);
    tick();
    s_mem_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("lock_hold_addr_%0d", k), m_mem_addr, 32'h1000);
      chk($sformatf("lock_hold_gnt_%0d", k), s_mem_gnt, 0);
      tick();
    end
    m_mem_gnt = 1'b1;
    @(negedge clk);
    chk("lock_release_gnt", s_mem_gnt, 2'b10);
    chk("lock_release_addr", m_mem_addr, 32'h1000);
    tick();
    @(negedge clk);
    chk("after_lock_gnt", s_mem_gnt, 2'b01);
    chk("after_lock_addr", m_mem_addr, 32'h100);
    tick();
    s_mem_req = '0;
    m_mem_gnt = 1'b0;
    resp(1, 32'hC1);
    tick();
    resp(0, 32'hC0);
    tick();
    m_mem_valid = 1'b0;
    tick();

    // Orphan response with an empty FIFO
    @(negedge clk);
    chk("orphan_pre", orphan_err, 0);
    tick();
    m_mem_valid = 1'b1;
    m_mem_rdata = 32'hDD;
    @(negedge clk);
    chk("orphan_no_valid", s_mem_valid, 0);
    tick();
    m_mem_valid = 1'b0;
    @(negedge clk);
    chk("orphan_set", orphan_err, 1);
    tick();
    tick();
    @(negedge clk);
    chk("orphan_sticky", orphan_err, 1);
    tick();

    // Reset with two requests outstanding; late responses become orphans
    s_mem_req = 2'b11;
    m_mem_gnt = 1'b1;
    tick();
    tick();
    s_mem_req   = '0;
    m_mem_gnt   = 1'b0;
    m_mem_rdata = '0;
    @(negedge clk);
    chk("pre_reset_outstanding", outstanding, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outstanding", outstanding, 0);
    chk("mid_reset_orphan", orphan_err, 0);
    chk("mid_reset_valid", s_mem_valid, 0);
    chk("mid_reset_gnt", s_mem_gnt, 0);
    chk("mid_reset_m_req", m_mem_req, 0);
    chk("mid_reset_rdata", s_mem_rdata, 0);
    tick();
    m_mem_valid = 1'b1;
    m_mem_rdata = 32'hEE;
    @(negedge clk);
    chk("post_reset_no_valid", s_mem_valid, 0);
    tick();
    m_mem_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_orphan", orphan_err, 1);
    tick();

    // Grant at t, response at t+2; delivery at t+2+LAT
    s_mem_req = 2'b01;
    m_mem_gnt = 1'b1;
    tick();
    s_mem_req = '0;
    m_mem_gnt = 1'b0;
    tick();
    resp(0, 32'h5A);
    tick();
    m_mem_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("final_outstanding", outstanding, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
